// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder.
//   state_t : handshake FSM states
//   op_t    : latched request kind (read, write, or illegal RD&WR)
//   LEDS_OFS / SW_OFS : register offsets inside the I/O window
package mem_resp_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} op_t;

    localparam int LEDS_OFS = 0;
    localparam int SW_OFS   = 1;
endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM with registered read.
//   clk, rst : clock, async active-high reset (clears only the read register)
//   we, re   : write enable, read enable
//   addr     : word index
//   wdata    : write data
//   rdata    : read data register, updated on edges where re=1
module mem_resp_ram #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Handshaked memory-side responder: on-chip RAM plus an LED output register
// and a switch input register in an I/O window, with configurable wait states.
//   CLK, RST      : clock, async active-high reset
//   MADDR, DATA_O : request address and write data from the CPU
//   RD, WR        : level requests, held by the CPU until READY
//   DATA_I        : read data (holds until the next read completes)
//   READY, ERR    : one-cycle completion pulse and coincident error flag
//   LEDS          : register at IO_BASE;  SW : input read at IO_BASE+1
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int                 DATA_W      = 16,
    parameter int                 ADDR_W      = 16,
    parameter int                 DEPTH_LOG2  = 8,
    parameter int                 WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0]  IO_BASE     = 16'hFF00
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] MADDR,
    input  logic [DATA_W-1:0] DATA_O,
    input  logic              RD,
    input  logic              WR,
    output logic [DATA_W-1:0] DATA_I,
    output logic              READY,
    output logic              ERR,
    output logic [DATA_W-1:0] LEDS,
    input  logic [DATA_W-1:0] SW
);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [ADDR_W-1:0] LEDS_ADDR = IO_BASE + ADDR_W'(LEDS_OFS);
    localparam logic [ADDR_W-1:0] SW_ADDR   = IO_BASE + ADDR_W'(SW_OFS);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    op_t                op_q, op_e;
    logic [ADDR_W-1:0]  addr_q, addr_e;
    logic [DATA_W-1:0]  wdata_q, wdata_e;
    logic               err_q, src_ram;
    logic [DATA_W-1:0]  io_q, ram_rdata;
    logic               req_ok, req_bad, commit;
    logic               is_ram, is_leds, is_sw, dec_err;

    assign req_ok  = RD ^ WR;
    assign req_bad = RD & WR;

    // With zero wait states the commit happens on the sampling edge itself,
    // so in IDLE the live bus is used instead of the (not yet loaded) latches.
    always_comb begin
        op_e    = op_q;
        addr_e  = addr_q;
        wdata_e = wdata_q;
        if (state == IDLE) begin
            op_e    = req_bad ? OP_BAD : (WR ? OP_WR : OP_RD);
            addr_e  = MADDR;
            wdata_e = DATA_O;
        end
    end

    assign commit = (state == IDLE && (req_bad || (req_ok && WAIT_STATES == 0))) ||
                    (state == WAIT && cnt == CNT_W'(1));

    assign is_ram  = (addr_e >> DEPTH_LOG2) == '0;
    assign is_leds = addr_e == LEDS_ADDR;
    assign is_sw   = addr_e == SW_ADDR;
    assign dec_err = (op_e == OP_BAD) || !(is_ram || is_leds || is_sw) ||
                     (is_sw && op_e == OP_WR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_bad)     state_nx = ACK;
                  else if (req_ok) state_nx = (WAIT_STATES == 0) ? ACK : WAIT;
            WAIT: if (cnt == CNT_W'(1)) state_nx = ACK;
            ACK:  state_nx = HOLD;
            HOLD: if (!RD && !WR) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            src_ram <= 1'b0;
            io_q    <= '0;
            LEDS    <= '0;
        end else begin
            if (state == IDLE && (RD || WR)) begin
                op_q    <= op_e;
                addr_q  <= MADDR;
                wdata_q <= DATA_O;
                cnt     <= CNT_W'(WAIT_STATES);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                err_q <= dec_err;
                if (op_e == OP_WR && is_leds) LEDS <= wdata_e;
                // Only a genuine read updates DATA_I; decode errors read 0.
                if (op_e == OP_RD) begin
                    src_ram <= is_ram;
                    io_q    <= is_leds ? LEDS : (is_sw ? SW : '0);
                end
            end
        end
    end

    mem_resp_ram #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (CLK),
        .rst   (RST),
        .we    (commit && op_e == OP_WR && is_ram),
        .re    (commit && op_e == OP_RD && is_ram),
        .addr  (addr_e[DEPTH_LOG2-1:0]),
        .wdata (wdata_e),
        .rdata (ram_rdata)
    );

    // RAM data lives in the RAM's own read register; src_ram picks which
    // register currently owns DATA_I.
    assign DATA_I = src_ram ? ram_rdata : io_q;
    assign READY  = (state == ACK);
    assign ERR    = (state == ACK) && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Two responders (2 wait states and 0 wait states) share one bus stimulus;
// results are compared with a behavioural memory/register model.
module tb_mem_responder;
    logic        clk = 1'b0, rst = 1'b1, rd = 1'b0, wr = 1'b0;
    logic [15:0] maddr = '0, data_o = '0, sw = '0;
    logic [15:0] data_i2, leds2, data_i0, leds0;
    logic        ready2, err2, ready0, err0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(2)) dut (
        .CLK(clk), .RST(rst), .MADDR(maddr), .DATA_O(data_o), .RD(rd), .WR(wr),
        .DATA_I(data_i2), .READY(ready2), .ERR(err2), .LEDS(leds2), .SW(sw));

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .CLK(clk), .RST(rst), .MADDR(maddr), .DATA_O(data_o), .RD(rd), .WR(wr),
        .DATA_I(data_i0), .READY(ready0), .ERR(err0), .LEDS(leds0), .SW(sw));

    int n_cmp = 0, n_bad = 0;

    // reference model state
    logic [15:0] ref_mem [256];
    logic [15:0] ref_leds = '0, ref_dat = '0;
    logic        e_err;
    int          e_lat2;

    // observed transaction results
    int          x_lat2, x_lat0, x_extra;
    logic        x_err2, x_err0;
    logic [15:0] x_q2, x_q0;

    task automatic step(input int c);
        @(posedge clk); #1;
        if (ready2) begin
            if (x_lat2 < 0) begin x_lat2 = c; x_err2 = err2; x_q2 = data_i2; end
            else x_extra++;
        end
        if (ready0) begin
            if (x_lat0 < 0) begin x_lat0 = c; x_err0 = err0; x_q0 = data_i0; end
            else x_extra++;
        end
    endtask

    // Drive one request, hold it until both responders have answered plus
    // 'hold' cycles, then release and let both return to idle.
    task automatic xact(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input int hold);
        x_lat2 = -1; x_lat0 = -1; x_extra = 0;
        x_err2 = 1'bx; x_err0 = 1'bx; x_q2 = 'x; x_q0 = 'x;
        rd = r; wr = w; maddr = a; data_o = d;
        for (int c = 1; c <= 20 && (x_lat2 < 0 || x_lat0 < 0); c++) step(c);
        for (int h = 0; h < hold; h++) step(99);
        rd = 1'b0; wr = 1'b0;
        step(99); step(99);
    endtask

    task automatic model(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
        e_lat2 = (r && w) ? 1 : 3;
        e_err  = 1'b0;
        if (r && w) e_err = 1'b1;
        else if (a < 16'd256) begin
            if (w) ref_mem[a[7:0]] = d; else ref_dat = ref_mem[a[7:0]];
        end else if (a == 16'hFF00) begin
            if (w) ref_leds = d; else ref_dat = ref_leds;
        end else if (a == 16'hFF01) begin
            if (w) e_err = 1'b1; else ref_dat = sw;
        end else begin
            e_err = 1'b1;
            if (r) ref_dat = '0;
        end
    endtask

    task automatic run(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input int hold);
        model(r, w, a, d);
        xact(r, w, a, d, hold);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({data_i2, ready2, err2, leds2} !== 34'd0) begin
            n_bad++; $display("FAIL reset_dut2 got %h exp 0", {data_i2, ready2, err2, leds2});
        end
        n_cmp++;
        if ({data_i0, ready0, err0, leds0} !== 34'd0) begin
            n_bad++; $display("FAIL reset_dut0 got %h exp 0", {data_i0, ready0, err0, leds0});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        // known RAM contents for later reads
        for (int i = 0; i < 8; i++) run(1'b0, 1'b1, 16'(i), 16'($urandom), 0);
        run(1'b0, 1'b1, 16'h0020, 16'h0000, 0);
    endtask

    task automatic test_ram_rw();
        run(1'b0, 1'b1, 16'h0010, 16'h1234, 0);
        n_cmp++;
        if (x_lat2 !== 3 || x_lat0 !== 1) begin
            n_bad++; $display("FAIL wr_latency got %0d/%0d exp 3/1", x_lat2, x_lat0);
        end
        n_cmp++;
        if (x_err2 !== 1'b0 || x_err0 !== 1'b0) begin
            n_bad++; $display("FAIL wr_err got %b/%b exp 0/0", x_err2, x_err0);
        end
        run(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
        n_cmp++;
        if (x_lat2 !== 3 || x_lat0 !== 1) begin
            n_bad++; $display("FAIL rd_latency got %0d/%0d exp 3/1", x_lat2, x_lat0);
        end
        n_cmp++;
        if (x_q2 !== 16'h1234 || x_q0 !== 16'h1234 || x_err2 !== 1'b0) begin
            n_bad++; $display("FAIL rd_data got %h/%h err %b exp 1234", x_q2, x_q0, x_err2);
        end
    endtask

    task automatic test_io();
        run(1'b0, 1'b1, 16'hFF00, 16'hA5A5, 0);
        n_cmp++;
        if (leds2 !== 16'hA5A5 || leds0 !== 16'hA5A5) begin
            n_bad++; $display("FAIL leds_write got %h/%h exp a5a5", leds2, leds0);
        end
        sw = 16'h0F0F;
        run(1'b1, 1'b0, 16'hFF01, 16'h0000, 0);
        n_cmp++;
        if (x_q2 !== 16'h0F0F || x_q0 !== 16'h0F0F || x_err2 !== 1'b0) begin
            n_bad++; $display("FAIL sw_read got %h/%h err %b exp 0f0f", x_q2, x_q0, x_err2);
        end
        run(1'b1, 1'b0, 16'hFF00, 16'h0000, 0);
        n_cmp++;
        if (x_q2 !== 16'hA5A5 || x_q0 !== 16'hA5A5) begin
            n_bad++; $display("FAIL leds_read got %h/%h exp a5a5", x_q2, x_q0);
        end
    endtask

    task automatic test_errors();
        run(1'b1, 1'b0, 16'h0100, 16'h0000, 0);
        n_cmp++;
        if (x_err2 !== 1'b1 || x_err0 !== 1'b1 || x_q2 !== 16'h0 || x_q0 !== 16'h0 || x_lat2 !== 3) begin
            n_bad++; $display("FAIL gap_read err %b/%b data %h/%h lat %0d exp 1/1 0 3",
                              x_err2, x_err0, x_q2, x_q0, x_lat2);
        end
        run(1'b0, 1'b1, 16'hFF01, 16'h1111, 0);
        n_cmp++;
        if (x_err2 !== 1'b1 || x_err0 !== 1'b1 || leds2 !== 16'hA5A5 || leds0 !== 16'hA5A5) begin
            n_bad++; $display("FAIL sw_write err %b/%b leds %h/%h exp 1/1 a5a5",
                              x_err2, x_err0, leds2, leds0);
        end
    endtask

    task automatic test_both_high();
        run(1'b0, 1'b1, 16'h0000, 16'h7777, 0);
        run(1'b1, 1'b1, 16'h0000, 16'h9999, 5);
        n_cmp++;
        if (x_err2 !== 1'b1 || x_err0 !== 1'b1 || x_lat2 !== 1 || x_lat0 !== 1) begin
            n_bad++; $display("FAIL rdwr_err err %b/%b lat %0d/%0d exp 1/1 1/1",
                              x_err2, x_err0, x_lat2, x_lat0);
        end
        n_cmp++;
        if (x_extra !== 0) begin
            n_bad++; $display("FAIL hold_single_ready got %0d extra pulses exp 0", x_extra);
        end
        run(1'b1, 1'b0, 16'h0000, 16'h0000, 0);
        n_cmp++;
        if (x_q2 !== 16'h7777 || x_q0 !== 16'h7777) begin
            n_bad++; $display("FAIL rdwr_no_write got %h/%h exp 7777", x_q2, x_q0);
        end
    endtask

    task automatic test_back_to_back();
        run(1'b0, 1'b1, 16'h0001, 16'h0101, 0);
        run(1'b0, 1'b1, 16'h0002, 16'h0202, 0);
        run(1'b1, 1'b0, 16'h0001, 16'h0000, 0);
        n_cmp++;
        if (x_lat0 !== 1 || x_q0 !== 16'h0101) begin
            n_bad++; $display("FAIL b2b_first lat %0d data %h exp 1 0101", x_lat0, x_q0);
        end
        run(1'b1, 1'b0, 16'h0002, 16'h0000, 0);
        n_cmp++;
        if (x_lat0 !== 1 || x_q0 !== 16'h0202) begin
            n_bad++; $display("FAIL b2b_second lat %0d data %h exp 1 0202", x_lat0, x_q0);
        end
    endtask

    task automatic test_reset_midwait();
        rd = 1'b0; wr = 1'b1; maddr = 16'h0020; data_o = 16'hBEEF;
        @(posedge clk); #1;   // sampled: dut in WAIT, dut0 already committed
        rst = 1'b1; #1;
        n_cmp++;
        if ({data_i2, ready2, err2, leds2} !== 34'd0 || {data_i0, ready0, err0, leds0} !== 34'd0) begin
            n_bad++; $display("FAIL reset_midwait got %h/%h exp 0",
                              {data_i2, ready2, err2, leds2}, {data_i0, ready0, err0, leds0});
        end
        wr = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        ref_leds = '0; ref_dat = '0;
        xact(1'b1, 1'b0, 16'h0020, 16'h0000, 0);
        n_cmp++;
        if (x_q2 !== 16'h0000) begin
            n_bad++; $display("FAIL dropped_write got %h exp 0000", x_q2);
        end
        n_cmp++;
        if (x_q0 !== 16'hBEEF) begin
            n_bad++; $display("FAIL zero_wait_committed got %h exp beef", x_q0);
        end
        // bring both responders back to identical state
        run(1'b0, 1'b1, 16'h0020, 16'h0000, 0);
        run(1'b1, 1'b0, 16'h0020, 16'h0000, 0);
    endtask

    task automatic test_random();
        logic [15:0] a, d;
        bit r, w;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                5:       a = 16'hFF00;
                6:       a = 16'hFF01;
                7:       a = 16'h0100;
                8:       a = 16'hFFFF;
                9:       a = 16'h8000;
                default: a = 16'($urandom_range(0, 7));
            endcase
            case ($urandom_range(0, 9))
                0:          begin r = 1'b1; w = 1'b1; end
                1, 2, 3, 4: begin r = 1'b0; w = 1'b1; end
                default:    begin r = 1'b1; w = 1'b0; end
            endcase
            d  = 16'($urandom);
            sw = 16'($urandom);
            run(r, w, a, d, $urandom_range(0, 3));
            n_cmp++;
            if (x_lat2 !== e_lat2 || x_lat0 !== 1 || x_extra !== 0) begin
                n_bad++; $display("FAIL rnd%0d_timing lat %0d/%0d extra %0d exp %0d/1 0",
                                  n, x_lat2, x_lat0, x_extra, e_lat2);
            end
            n_cmp++;
            if (x_err2 !== e_err || x_err0 !== e_err) begin
                n_bad++; $display("FAIL rnd%0d_err a=%h got %b/%b exp %b", n, a, x_err2, x_err0, e_err);
            end
            n_cmp++;
            if (x_q2 !== ref_dat || x_q0 !== ref_dat) begin
                n_bad++; $display("FAIL rnd%0d_data a=%h got %h/%h exp %h", n, a, x_q2, x_q0, ref_dat);
            end
            n_cmp++;
            if (leds2 !== ref_leds || leds0 !== ref_leds) begin
                n_bad++; $display("FAIL rnd%0d_leds got %h/%h exp %h", n, leds2, leds0, ref_leds);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_io();
        test_errors();
        test_both_high();
        test_back_to_back();
        test_reset_midwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
